// File: rtl/soc_ahb4_pkg.sv
// Shared AHB4 constants, responder state type and byte-lane decode.
package soc_ahb4_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_ACT,
      RSP_ERR1,
      RSP_ERR2
   } rsp_state_e;

   // Little-endian byte enables; lane offset is the address bits below the bus width.
   function automatic logic [7:0] byte_en(input logic [2:0] hsize,
                                          input logic [2:0] addr_lo,
                                          input int unsigned xlen);
      logic [7:0] m;
      logic [2:0] lane;
      case (hsize)
         HSIZE_BYTE:  m = 8'h01;
         HSIZE_HALF:  m = 8'h03;
         HSIZE_WORD:  m = 8'h0F;
         HSIZE_DWORD: m = 8'hFF;
         default:     m = 8'hFF;
      endcase
      lane = addr_lo & 3'(xlen / 8 - 1);
      return m << lane;
   endfunction

endpackage

// File: rtl/soc_ahb4_ext_ram.sv
// Local word memory: per-byte write enables, one write port, one combinational read port.
module soc_ahb4_ext_ram #(
   parameter  int XLEN      = 32,
   parameter  int MEM_WORDS = 1024,
   localparam int AW        = $clog2(MEM_WORDS),
   localparam int NB        = XLEN / 8
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [NB-1:0]   be_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] mem_q [MEM_WORDS];

   // Byte-lane write; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/soc_ahb4_ext_responder.sv
// AHB4-Lite responder terminating a tile's external port with local memory.
module soc_ahb4_ext_responder
   import soc_ahb4_pkg::*;
#(
   parameter int              PLEN        = 32,
   parameter int              XLEN        = 32,
   parameter int              MEM_WORDS   = 1024,
   parameter logic [PLEN-1:0] BASE_ADDR   = '0,
   parameter int              WAIT_STATES = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ahb4_ext_hsel_i,
   input  logic [PLEN-1:0] ahb4_ext_haddr_i,
   input  logic [XLEN-1:0] ahb4_ext_hwdata_i,
   input  logic            ahb4_ext_hwrite_i,
   input  logic [2:0]      ahb4_ext_hsize_i,
   input  logic [2:0]      ahb4_ext_hburst_i,
   input  logic [3:0]      ahb4_ext_hprot_i,
   input  logic [1:0]      ahb4_ext_htrans_i,
   input  logic            ahb4_ext_hmastlock_i,
   output logic [XLEN-1:0] ahb4_ext_hrdata_o,
   output logic            ahb4_ext_hready_o,
   output logic            ahb4_ext_hresp_o
);

   localparam int              NB        = XLEN / 8;
   localparam int              SZ        = $clog2(NB);
   localparam int              AW        = $clog2(MEM_WORDS);
   localparam logic [PLEN:0]   MEM_BYTES = (PLEN+1)'(MEM_WORDS * NB);

   rsp_state_e      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [2:0]      lo_q, lo_d;
   logic [2:0]      hsize_q, hsize_d;
   logic            hwrite_q, hwrite_d;

   logic            accept, err, misalign;
   logic [PLEN:0]   off;
   logic [7:0]      amask, be_full;
   logic [XLEN-1:0] rd_word;
   logic            we;

   // Error decode on the live address phase; an address below BASE_ADDR wraps
   // into the top bit of off and so also fails the range compare.
   always_comb begin
      off      = {1'b0, ahb4_ext_haddr_i} - {1'b0, BASE_ADDR};
      amask    = (8'd1 << ahb4_ext_hsize_i) - 8'd1;
      misalign = |(ahb4_ext_haddr_i[2:0] & amask[2:0]);
      err      = (off >= MEM_BYTES) || (ahb4_ext_hsize_i > 3'(SZ)) || misalign;
   end

   // FSM next state, handshake outputs and address/control capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lo_d     = lo_q;
      hsize_d  = hsize_q;
      hwrite_d = hwrite_q;
      ahb4_ext_hready_o = 1'b1;
      ahb4_ext_hresp_o  = HRESP_OKAY;
      case (state_q)
         RSP_WAIT: ahb4_ext_hready_o = 1'b0;
         RSP_ERR1: begin
            ahb4_ext_hready_o = 1'b0;
            ahb4_ext_hresp_o  = HRESP_ERROR;
         end
         RSP_ERR2: ahb4_ext_hresp_o = HRESP_ERROR;
         default: ;
      endcase
      accept = ahb4_ext_hready_o && ahb4_ext_hsel_i &&
               (ahb4_ext_htrans_i == HTRANS_NONSEQ || ahb4_ext_htrans_i == HTRANS_SEQ);
      case (state_q)
         RSP_WAIT: begin
            if (cnt_q == 3'd0) state_d = RSP_ACT;
            else               cnt_d   = cnt_q - 3'd1;
         end
         RSP_ERR1: state_d = RSP_ERR2;
         default: begin
            // IDLE, ACT and ERR2 all present hready=1, so a new address phase may land here.
            if (accept) begin
               idx_d    = off[SZ +: AW];
               lo_d     = ahb4_ext_haddr_i[2:0];
               hsize_d  = ahb4_ext_hsize_i;
               hwrite_d = ahb4_ext_hwrite_i;
               if (err)                   state_d = RSP_ERR1;
               else if (WAIT_STATES == 0) state_d = RSP_ACT;
               else begin
                  state_d = RSP_WAIT;
                  cnt_d   = 3'(WAIT_STATES - 1);
               end
            end else begin
               state_d = RSP_IDLE;
            end
         end
      endcase
   end

   // State and captured address/control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RSP_IDLE;
         cnt_q    <= 3'd0;
         idx_q    <= '0;
         lo_q     <= 3'd0;
         hsize_q  <= 3'd0;
         hwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lo_q     <= lo_d;
         hsize_q  <= hsize_d;
         hwrite_q <= hwrite_d;
      end
   end

   // Writes commit on the edge closing ACT; ERR states never reach ACT.
   assign we      = (state_q == RSP_ACT) && hwrite_q;
   assign be_full = byte_en(hsize_q, lo_q, XLEN);

   soc_ahb4_ext_ram #(
      .XLEN      (XLEN),
      .MEM_WORDS (MEM_WORDS)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (we),
      .be_i    (be_full[NB-1:0]),
      .waddr_i (idx_q),
      .wdata_i (ahb4_ext_hwdata_i),
      .raddr_i (idx_q),
      .rdata_o (rd_word)
   );

   assign ahb4_ext_hrdata_o = (state_q == RSP_ACT && !hwrite_q) ? rd_word : '0;

   logic unused_ok;
   assign unused_ok = ^{off, be_full, ahb4_ext_hburst_i, ahb4_ext_hprot_i, ahb4_ext_hmastlock_i};

endmodule

// File: tb/tb_soc_ahb4_ext_responder.sv
// Bench: two responders (0 and 3 wait states) on a shared bus, table-driven pipelined traffic.
module tb_soc_ahb4_ext_responder;
   import soc_ahb4_pkg::*;

   logic        clk, rst;
   logic        hsel, hwrite;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   int          sel;
   logic        hsel0, hsel3;
   logic [31:0] hrdata0, hrdata3, hrdata_m;
   logic        hready0, hready3, hready_m;
   logic        hresp0, hresp3, hresp_m;

   assign hsel0    = hsel && (sel == 0);
   assign hsel3    = hsel && (sel == 1);
   assign hready_m = (sel == 0) ? hready0 : hready3;
   assign hresp_m  = (sel == 0) ? hresp0  : hresp3;
   assign hrdata_m = (sel == 0) ? hrdata0 : hrdata3;

   soc_ahb4_ext_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst),
      .ahb4_ext_hsel_i(hsel0), .ahb4_ext_haddr_i(haddr), .ahb4_ext_hwdata_i(hwdata),
      .ahb4_ext_hwrite_i(hwrite), .ahb4_ext_hsize_i(hsize), .ahb4_ext_hburst_i(3'd0),
      .ahb4_ext_hprot_i(4'd0), .ahb4_ext_htrans_i(htrans), .ahb4_ext_hmastlock_i(1'b0),
      .ahb4_ext_hrdata_o(hrdata0), .ahb4_ext_hready_o(hready0), .ahb4_ext_hresp_o(hresp0));

   soc_ahb4_ext_responder #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .rst(rst),
      .ahb4_ext_hsel_i(hsel3), .ahb4_ext_haddr_i(haddr), .ahb4_ext_hwdata_i(hwdata),
      .ahb4_ext_hwrite_i(hwrite), .ahb4_ext_hsize_i(hsize), .ahb4_ext_hburst_i(3'd0),
      .ahb4_ext_hprot_i(4'd0), .ahb4_ext_htrans_i(htrans), .ahb4_ext_hmastlock_i(1'b0),
      .ahb4_ext_hrdata_o(hrdata3), .ahb4_ext_hready_o(hready3), .ahb4_ext_hresp_o(hresp3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          waits;
      string       nm;
   } exp_t;

   vec_t tbl[24];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_bus();
      hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      haddr = '0; hsize = HSIZE_WORD; hwdata = '0;
   endtask

   // Pipelined master: next address phase overlaps the current data phase.
   // Called and returns at 1 time unit after a rising edge.
   task automatic run_ops(input int s, input int first, input int last);
      int   cur    = first;
      int   dph    = -1;
      int   waits  = 0;
      int   wbad   = 0;
      int   budget = 0;
      int   ws     = (s == 0) ? 0 : 3;
      logic rdy;
      exp_t e;
      sel = s;
      while ((cur <= last || dph >= 0) && budget < 400) begin
         if (cur <= last) begin
            hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = tbl[cur].addr;
            hwrite = tbl[cur].wr; hsize = tbl[cur].size;
         end else begin
            hsel = 1'b0; htrans = HTRANS_IDLE;
         end
         hwdata = (dph >= 0) ? tbl[dph].wdata : 32'h0;
         #0;
         rdy = hready_m;
         if (dph >= 0) begin
            if (!rdy) begin
               waits++;
               if (hresp_m !== tbl[dph].err || hrdata_m !== 32'h0) wbad++;
            end else begin
               e = sb.pop_front();
               chk({e.nm, " hresp"},  hresp_m,  e.err);
               chk({e.nm, " hrdata"}, hrdata_m, e.rdata);
               chk({e.nm, " waits"},  waits,    e.waits);
               chk({e.nm, " wait-cycle outputs bad"}, wbad, 0);
               waits = 0; wbad = 0;
            end
         end
         if (rdy) begin
            if (cur <= last) begin
               e.err   = tbl[cur].err;
               e.rdata = (tbl[cur].wr || tbl[cur].err) ? 32'h0 : tbl[cur].rdata;
               e.waits = tbl[cur].err ? 1 : ws;
               e.nm    = $sformatf("dut%0d v%0d", s, cur);
               sb.push_back(e);
               dph = cur;
               cur++;
            end else begin
               dph = -1;
            end
         end
         @(posedge clk); #1;
         budget++;
      end
      if (budget >= 400) begin
         n_vec++; n_bad++;
         $display("FAIL dut%0d run timeout: got %0d cycles expected < 400", s, budget);
      end
      idle_bus();
      // Last data phase ended with no new transfer: back to IDLE.
      chk($sformatf("dut%0d post hready", s), hready_m, 1'b1);
      chk($sformatf("dut%0d post hresp", s),  hresp_m,  1'b0);
      chk($sformatf("dut%0d post hrdata", s), hrdata_m, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          wr  addr          size         wdata          err  rdata
      tbl[0]  = '{1, 32'h0000_0000, HSIZE_WORD, 32'hCAFE_F00D, 0, 32'h0};
      tbl[1]  = '{1, 32'h0000_0010, HSIZE_WORD, 32'hDEAD_BEEF, 0, 32'h0};
      tbl[2]  = '{0, 32'h0000_0010, HSIZE_WORD, 32'h0,         0, 32'hDEAD_BEEF};
      tbl[3]  = '{1, 32'h0000_0010, HSIZE_WORD, 32'h0000_0000, 0, 32'h0};
      tbl[4]  = '{1, 32'h0000_0011, HSIZE_BYTE, 32'h0000_AB00, 0, 32'h0};
      tbl[5]  = '{1, 32'h0000_0012, HSIZE_HALF, 32'h1234_0000, 0, 32'h0};
      tbl[6]  = '{0, 32'h0000_0010, HSIZE_WORD, 32'h0,         0, 32'h1234_AB00};
      tbl[7]  = '{0, 32'h0000_1000, HSIZE_WORD, 32'h0,         1, 32'h0};
      tbl[8]  = '{0, 32'h0000_0002, HSIZE_WORD, 32'h0,         1, 32'h0};
      tbl[9]  = '{0, 32'h0000_0010, HSIZE_DWORD,32'h0,         1, 32'h0};
      tbl[10] = '{1, 32'h0000_0012, HSIZE_WORD, 32'hFFFF_FFFF, 1, 32'h0};
      tbl[11] = '{1, 32'h0000_1000, HSIZE_BYTE, 32'h0000_00EE, 1, 32'h0};
      tbl[12] = '{0, 32'h0000_0010, HSIZE_WORD, 32'h0,         0, 32'h1234_AB00};
      tbl[13] = '{0, 32'h0000_0000, HSIZE_WORD, 32'h0,         0, 32'hCAFE_F00D};
      tbl[14] = '{0, 32'h0000_0013, HSIZE_BYTE, 32'h0,         0, 32'h1234_AB00};
      tbl[15] = '{0, 32'h0000_0011, HSIZE_HALF, 32'h0,         1, 32'h0};
      tbl[16] = '{1, 32'h0000_0020, HSIZE_WORD, 32'h1111_1111, 0, 32'h0};
      tbl[17] = '{0, 32'h0000_0020, HSIZE_WORD, 32'h0,         0, 32'h1111_1111};
      tbl[18] = '{1, 32'h0000_0024, HSIZE_WORD, 32'h0000_0000, 0, 32'h0};
      tbl[19] = '{1, 32'h0000_0027, HSIZE_BYTE, 32'h5A00_0000, 0, 32'h0};
      tbl[20] = '{0, 32'h0000_0024, HSIZE_WORD, 32'h0,         0, 32'h5A00_0000};
      tbl[21] = '{0, 32'h0000_1000, HSIZE_WORD, 32'h0,         1, 32'h0};
      tbl[22] = '{0, 32'h0000_0020, HSIZE_WORD, 32'h0,         0, 32'h1111_1111};
      tbl[23] = '{0, 32'h0000_0020, HSIZE_WORD, 32'h0,         0, 32'h1111_1111};

      sel = 0;
      rst = 1'b0;
      idle_bus();
      // Reset held for three cycles: both responders idle throughout.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("rst c%0d hready0", c), hready0, 1'b1);
         chk($sformatf("rst c%0d hresp0", c),  hresp0,  1'b0);
         chk($sformatf("rst c%0d hrdata0", c), hrdata0, 32'h0);
         chk($sformatf("rst c%0d hready3", c), hready3, 1'b1);
      end
      rst = 1'b1;

      // NONSEQ without select, then BUSY with select: no transfer either way.
      hsel = 1'b0; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 1'b1;
      @(posedge clk); #1;
      chk("nosel hready0", hready0, 1'b1);
      chk("nosel hresp0",  hresp0,  1'b0);
      chk("nosel hready3", hready3, 1'b1);
      hsel = 1'b1; htrans = HTRANS_BUSY; hwrite = 1'b0;
      @(posedge clk); #1;
      chk("busy hready0", hready0, 1'b1);
      chk("busy hresp0",  hresp0,  1'b0);
      chk("busy hrdata0", hrdata0, 32'h0);
      idle_bus();
      @(posedge clk); #1;

      run_ops(0, 0, 15);
      run_ops(1, 16, 22);

      // Reset during the second wait cycle of a write drops the write.
      sel = 1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h2222_2222;
      chk("midrst wait1 hready", hready_m, 1'b0);
      @(posedge clk); #1;
      chk("midrst wait2 hready", hready_m, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst hready", hready_m, 1'b1);
      chk("midrst hresp",  hresp_m,  1'b0);
      chk("midrst hrdata", hrdata_m, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      idle_bus();
      @(posedge clk); #1;
      run_ops(1, 23, 23);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/soc_ahb4_ext_responder.md
# soc_ahb4_ext_responder

AHB4-Lite slave that terminates one tile's external AHB4 master port (`ahb4_ext_*`) of the MPSoC with a local byte-addressable memory. It sits outside the tile array, one instance per node, and provides OKAY/ERROR responses, a configurable number of wait states and little-endian byte-lane writes. It is the responder end of the tile's external bus: it captures address phases, runs data phases and drives `hready`/`hresp`/`hrdata` back to the tile.

## Interface
- PLEN, 32, address width.
- XLEN, 32, data width; legal values 32 or 64.
- MEM_WORDS, 1024, memory depth in XLEN-bit words; power of two.
- BASE_ADDR, 0, byte address of word 0.
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase; range 0..7.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- ahb4_ext_hsel_i  in  1  slave select.
- ahb4_ext_haddr_i  in  PLEN  byte address.
- ahb4_ext_hwdata_i  in  XLEN  write data, valid in data phase.
- ahb4_ext_hwrite_i  in  1  1 = write.
- ahb4_ext_hsize_i  in  3  transfer size.
- ahb4_ext_hburst_i  in  3  burst type; ignored.
- ahb4_ext_hprot_i  in  4  protection; ignored.
- ahb4_ext_htrans_i  in  2  IDLE/BUSY/NONSEQ/SEQ.
- ahb4_ext_hmastlock_i  in  1  locked transfer; ignored.
- ahb4_ext_hrdata_o  out  XLEN  read data.
- ahb4_ext_hready_o  out  1  transfer done / address accepted.
- ahb4_ext_hresp_o  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase accepted on a rising edge where `hready_o=1 && hsel_i && htrans_i[1]`. At that edge, haddr, hwrite and hsize are registered and `err_q` is computed.
- `err_q` is set when any of these holds:
  - the address falls outside [BASE_ADDR, BASE_ADDR + MEM_WORDS·XLEN/8).
  - hsize exceeds log2(XLEN/8).
  - the address is not aligned to the transfer size.
- IDLE/BUSY, or no hsel: no transfer. The next cycle returns zero-wait OKAY with no memory access.
- States:
  - IDLE: hready=1, hresp=0.
  - WAIT: hready=0, hresp=0; counter counts down.
  - ACT: hready=1, hresp=0; final data cycle.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions on an accepted transfer from IDLE, ACT or ERR2:
  - err → ERR1.
  - WAIT_STATES=0 → ACT.
  - otherwise → WAIT, with the counter loaded to WAIT_STATES-1.
- WAIT → ACT when the counter reaches 0. ERR1 → ERR2 always.
- From ACT or ERR2 with no accepted transfer → IDLE.
- Word index = (haddr_q - BASE_ADDR) >> log2(XLEN/8). Byte lanes come from hsize_q and haddr_q low bits, little-endian.
- Writes commit the selected lanes of hwdata_i on the edge that ends ACT. Unselected lanes are unchanged. An error transfer never writes.
- Reads: in ACT, hrdata_o = the full addressed word. In every other state, and for writes, hrdata_o = 0.
- Back-to-back write then read of the same address returns the new data, because the commit precedes the read's data phase.
- A new address phase presented in ERR2 is accepted normally. A master that drives IDLE in ERR2 cancels nothing further.

## Timing
- Reset values: hready_o=1, hresp_o=0, hrdata_o=0, state IDLE, counter 0.
- Memory contents are not reset.
- Reset asserted mid-transfer forces IDLE immediately. A pending write is dropped.
- OKAY latency: data phase lasts 1 + WAIT_STATES cycles.
- ERROR latency: always exactly 2 cycles, independent of WAIT_STATES.
- Pipelined transfers sustain one transfer per 1 + WAIT_STATES cycles. No idle bubble is inserted between back-to-back transfers.
- Address/control inputs are sampled only at accepting edges. hwdata_i is sampled only at the ACT edge.

## Structure
- Shared package `soc_ahb4_pkg` holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD/DWORD and HRESP_OKAY/ERROR constants.
  - The responder state enum typedef.
  - A byte-enable function of (hsize, addr low bits, XLEN).
- Sub-module `soc_ahb4_ext_ram` is a MEM_WORDS × XLEN register array with per-byte write enable, one write port and one combinational read port.
- Top level holds the FSM, wait counter, address/control registers and error decode.

## Test plan
- Reset, then idle: rst low for 3 cycles → hready_o=1, hresp_o=0, hrdata_o=0 throughout. NONSEQ with hsel=0 → no response change.
- Word write/read with WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → hready_o never low, read ACT shows hrdata_o=0xDEADBEEF.
- Byte lanes: word 0x10 holds 0x00000000. Byte write 0xAB to 0x11, then half write 0x1234 to 0x12 → read 0x10 returns 0x1234AB00.
- Wait states with WAIT_STATES=3: single read → hready_o low for exactly 3 cycles, then high with data. Pipelined second NONSEQ is accepted on that same edge.
- Errors, both cycles hresp_o=1 with hready 0 then 1:
  - read at BASE_ADDR + MEM_WORDS·4.
  - word access at 0x02.
  - hsize=DWORD with XLEN=32.
  - For an erroneous write, memory is unchanged on readback.
- Reset mid-operation: assert rst in the second WAIT cycle of a write to 0x20 holding 0x11111111 → immediate IDLE outputs. Readback after reset returns 0x11111111.
